// File: rtl/pll_lock_ctrl.sv
// rtl/pll_lock_ctrl.sv - PLL lock sequencing: filter reset, acquire/track gain, lock detect, rail-fault retry.
module pll_lock_ctrl #(
    parameter int DAC_W         = 20,
    parameter int RST_CYCLES    = 16,
    parameter int ACQ_CYCLES    = 256,
    parameter int WIN           = 64,
    parameter int TOGGLE_MIN    = 8,
    parameter int LOCK_WINDOWS  = 4,
    parameter int UNLOCK_MISSES = 2,
    parameter int MAX_RETRY     = 3
) (
    input  logic             fref,
    input  logic             rst,
    input  logic             enable,
    input  logic             phase_error,
    input  logic [DAC_W-1:0] dac,
    output logic             filter_rst,
    output logic [1:0]       gain_sel,
    output logic             locked,
    output logic             lock_lost,
    output logic             fault,
    output logic [2:0]       state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HOLD   = 3'd1,
        S_ACQ    = 3'd2,
        S_TRACK  = 3'd3,
        S_LOCKED = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    localparam int DWELL_MAX = (ACQ_CYCLES > RST_CYCLES) ? ACQ_CYCLES : RST_CYCLES;
    localparam int CW = $clog2(DWELL_MAX + 1);
    localparam int WW = $clog2(WIN + 1);
    localparam int PW = $clog2(LOCK_WINDOWS + 1);
    localparam int MW = $clog2(UNLOCK_MISSES + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WW-1:0] win_q, win_d;
    logic [WW-1:0] tog_q, tog_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [MW-1:0] miss_q, miss_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          pe_q;
    logic          filter_rst_q, filter_rst_d;
    logic [1:0]    gain_q, gain_d;
    logic          locked_q, locked_d;
    logic          lock_lost_q, lock_lost_d;
    logic          fault_q, fault_d;

    logic          trans;
    logic          rail;
    logic          win_end;
    logic          win_pass;
    logic [WW-1:0] tog_upd;

    always_comb begin
        trans    = phase_error ^ pe_q;
        rail     = (dac == '0) || (dac == '1);
        tog_upd  = (trans && (tog_q != WW'(WIN))) ? tog_q + 1'b1 : tog_q;
        win_end  = (win_q == WW'(WIN - 1));
        win_pass = (tog_upd >= WW'(TOGGLE_MIN));

        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        tog_d       = tog_q;
        pass_d      = pass_q;
        miss_d      = miss_q;
        retry_d     = retry_q;
        lock_lost_d = 1'b0;

        if (!enable) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            win_d   = '0;
            tog_d   = '0;
            pass_d  = '0;
            miss_d  = '0;
            retry_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
                S_HOLD: begin
                    if (cnt_q == CW'(RST_CYCLES - 1)) begin
                        state_d = S_ACQ;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_ACQ: begin
                    if (cnt_q == CW'(ACQ_CYCLES - 1)) begin
                        state_d = S_TRACK;
                        cnt_d   = '0;
                        win_d   = '0;
                        tog_d   = '0;
                        pass_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_TRACK, S_LOCKED: begin
                    if (rail) begin
                        // Rail hit outranks the window verdict of the same cycle.
                        cnt_d  = '0;
                        win_d  = '0;
                        tog_d  = '0;
                        pass_d = '0;
                        miss_d = '0;
                        if (retry_q < RW'(MAX_RETRY)) begin
                            state_d = S_HOLD;
                            retry_d = retry_q + 1'b1;
                        end else begin
                            state_d = S_FAULT;
                        end
                    end else begin
                        win_d = win_end ? '0 : win_q + 1'b1;
                        tog_d = win_end ? '0 : tog_upd;
                        if (win_end && (state_q == S_TRACK)) begin
                            if (!win_pass) begin
                                pass_d = '0;
                            end else if (pass_q == PW'(LOCK_WINDOWS - 1)) begin
                                state_d = S_LOCKED;
                                pass_d  = '0;
                                miss_d  = '0;
                                retry_d = '0;
                            end else begin
                                pass_d = pass_q + 1'b1;
                            end
                        end else if (win_end) begin
                            if (win_pass) begin
                                miss_d = '0;
                            end else if (miss_q == MW'(UNLOCK_MISSES - 1)) begin
                                state_d     = S_ACQ;
                                miss_d      = '0;
                                cnt_d       = '0;
                                lock_lost_d = 1'b1;
                            end else begin
                                miss_d = miss_q + 1'b1;
                            end
                        end
                    end
                end
                S_FAULT: state_d = S_FAULT;
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    win_d   = '0;
                    tog_d   = '0;
                    pass_d  = '0;
                    miss_d  = '0;
                    retry_d = '0;
                end
            endcase
        end

        filter_rst_d = (state_d == S_IDLE) || (state_d == S_HOLD) || (state_d == S_FAULT);
        gain_d       = (state_d == S_TRACK) ? 2'b01 : (state_d == S_LOCKED) ? 2'b00 : 2'b10;
        locked_d     = (state_d == S_LOCKED);
        fault_d      = (state_d == S_FAULT);
    end

    always_ff @(posedge fref or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            win_q        <= '0;
            tog_q        <= '0;
            pass_q       <= '0;
            miss_q       <= '0;
            retry_q      <= '0;
            pe_q         <= 1'b0;
            filter_rst_q <= 1'b1;
            gain_q       <= 2'b10;
            locked_q     <= 1'b0;
            lock_lost_q  <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            win_q        <= win_d;
            tog_q        <= tog_d;
            pass_q       <= pass_d;
            miss_q       <= miss_d;
            retry_q      <= retry_d;
            pe_q         <= phase_error;
            filter_rst_q <= filter_rst_d;
            gain_q       <= gain_d;
            locked_q     <= locked_d;
            lock_lost_q  <= lock_lost_d;
            fault_q      <= fault_d;
        end
    end

    assign state      = state_q;
    assign filter_rst = filter_rst_q;
    assign gain_sel   = gain_q;
    assign locked     = locked_q;
    assign lock_lost  = lock_lost_q;
    assign fault      = fault_q;

endmodule
